jericalla_sequencer: RTL

Program sequencer for the Jericalla datapath. It holds a small buffer of 17-bit Jericalla instructions, loaded by a host, and issues them one at a time onto the datapath's `instruction` input. It holds each operand/opcode field stable for a settle window. It raises the RAM write-enable bit only in a single commit cycle. It can optionally halt the program when the ALU zero flag is set at commit. It sits between the host/test harness and the combinational ROM→ALU→RAM datapath, and is the only driver of its `instruction` bus.

---
 rtl/jericalla_pkg.sv | 19 +
 rtl/jericalla_instr_buf.sv | 27 ++
 rtl/jericalla_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/jericalla_pkg.sv
// Shared definitions for the Jericalla sequencer: instruction layout and FSM states.
package jericalla_pkg;

  localparam int INSTR_W  = 17;
  localparam int FIELD_W  = 4;
  localparam int EN_BIT   = 16;
  localparam int DIR1_LSB = 12;
  localparam int DIR2_LSB = 8;
  localparam int OP_LSB   = 4;
  localparam int DIRW_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DONE   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/jericalla_instr_buf.sv
// Instruction buffer: DEPTH x 17 register array, synchronous write, asynchronous read.
module jericalla_instr_buf
  import jericalla_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  // No reset: contents persist across rst so a program can be re-run.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/jericalla_sequencer.sv
// Program sequencer: issues buffered instructions with a settle window and
// a single-cycle write-enable commit, optionally halting on the ALU zero flag.
module jericalla_sequencer
  import jericalla_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int SETTLE = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_we,
  input  logic [AW-1:0]      load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               start,
  input  logic [AW:0]        len,
  input  logic               stop_on_zf,
  input  logic               zf,
  output logic [INSTR_W-1:0] instr_out,
  output logic [AW-1:0]      pc,
  output logic               busy,
  output logic               done,
  output logic               zf_halt
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  seq_state_t         state_reg, state_next;
  logic [AW-1:0]      pc_reg;
  logic [CW-1:0]      cnt_reg;
  logic [AW:0]        len_reg;
  logic               stop_reg;
  logic               zf_halt_reg;
  logic [INSTR_W-1:0] rd_data;
  logic               buf_we;
  logic               last_slot;
  logic               settle_end;
  logic               halt_now;
  logic [AW:0]        len_clamped;

  // The program is frozen while executing; writes land only in IDLE/DONE.
  assign buf_we = load_we && (state_reg == ST_IDLE || state_reg == ST_DONE);

  jericalla_instr_buf #(.DEPTH(DEPTH)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc_reg),
    .rdata (rd_data)
  );

  assign len_clamped = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
  assign last_slot   = ({1'b0, pc_reg} == (len_reg - 1'b1));
  assign settle_end  = (cnt_reg == CW'(SETTLE - 1));
  assign halt_now    = stop_reg && zf;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = (len == '0) ? ST_DONE : ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (settle_end) begin
          state_next = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        if (halt_now || last_slot) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_SETUP;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg      <= '0;
      cnt_reg     <= '0;
      len_reg     <= '0;
      stop_reg    <= 1'b0;
      zf_halt_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            pc_reg      <= '0;
            cnt_reg     <= '0;
            len_reg     <= len_clamped;
            stop_reg    <= stop_on_zf;
            zf_halt_reg <= 1'b0;
          end
        end
        ST_SETUP: begin
          cnt_reg <= cnt_reg + 1'b1;
        end
        ST_COMMIT: begin
          cnt_reg <= '0;
          if (halt_now) begin
            zf_halt_reg <= 1'b1;
          end else if (!last_slot) begin
            pc_reg <= pc_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Enable bit is masked during settle so the datapath never writes early.
  always_comb begin
    instr_out = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_reg)
      ST_SETUP: begin
        instr_out         = rd_data;
        instr_out[EN_BIT] = 1'b0;
        busy              = 1'b1;
      end
      ST_COMMIT: begin
        instr_out = rd_data;
        busy      = 1'b1;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc      = pc_reg;
  assign zf_halt = zf_halt_reg;

endmodule
